// File: rtl/multicycle_controller.sv
// multicycle_controller: one-state-per-clock sequencer for a shared-ALU RV datapath.
// Define MEM_READY_EN to honour mem_ready; otherwise memory is single-cycle.
module multicycle_controller #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opCode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] resultSrc,
  output logic       adrSrc,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic       regWrite,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JAL    = 4'd10;
  localparam logic [3:0] S_JALR   = 4'd11;
  localparam logic [3:0] S_JALR2  = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd15;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0000111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0000010;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [3:0] st;
  logic [3:0] nxt;
  logic       rdy;

`ifdef MEM_READY_EN
  assign rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign rdy = 1'b1;
`endif

  logic is_r, is_lw, is_sw, is_br;
  logic is_addi, is_jal, is_jalr;

  assign is_r    = opCode == OP_R;
  assign is_lw   = opCode == OP_LW;
  assign is_sw   = opCode == OP_SW;
  assign is_br   = opCode == OP_BR;
  assign is_addi = opCode == OP_ADDI;
  assign is_jal  = opCode == OP_JAL;
  assign is_jalr = opCode == OP_JALR;

  logic bad_op;
  assign bad_op = !(is_r | is_lw | is_sw | is_br |
                    is_addi | is_jal | is_jalr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= S_FETCH;
    else        st <= nxt;
  end

  always_comb begin
    nxt = S_FETCH;
    case (st)
      S_FETCH:  nxt = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: nxt = S_MEMADR;
          is_r:         nxt = S_EXECR;
          is_addi:      nxt = S_EXECI;
          is_br:        nxt = S_BRANCH;
          is_jal:       nxt = S_JAL;
          is_jalr:      nxt = S_JALR;
          default:      nxt = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        unique case (1'b1)
          is_lw:   nxt = S_MEMRD;
          is_sw:   nxt = S_MEMWR;
          default: nxt = S_FETCH;
        endcase
      end
      S_MEMRD:  nxt = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  nxt = rdy ? S_FETCH : S_MEMWR;
      S_EXECR:  nxt = S_ALUWB;
      S_EXECI:  nxt = S_ALUWB;
      S_ALUWB:  nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_JAL:    nxt = S_ALUWB;
      S_JALR:   nxt = S_JALR2;
      S_JALR2:  nxt = S_ALUWB;
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_FETCH;
    endcase
  end

  logic ir_w, pc_w, mem_r, mem_w, reg_w, ill;

  always_comb begin
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    resultSrc = 2'b00;
    adrSrc    = 1'b0;
    ir_w      = 1'b0;
    pc_w      = 1'b0;
    mem_r     = 1'b0;
    mem_w     = 1'b0;
    reg_w     = 1'b0;
    ill       = 1'b0;
    case (st)
      S_FETCH: begin
        mem_r     = 1'b1;
        ALUSrcB   = 2'b10;
        resultSrc = 2'b10;
        ir_w      = rdy;
        pc_w      = rdy;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ill     = bad_op && !TRAP_ON_ILLEGAL;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMRD: begin
        adrSrc = 1'b1;
        mem_r  = 1'b1;
      end
      S_MEMWB: begin
        resultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      S_MEMWR: begin
        adrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b11;
      end
      S_ALUWB: reg_w = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        pc_w    = zero;
      end
      S_JAL, S_JALR2: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_w    = 1'b1;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_TRAP: ill = 1'b1;
      default: ;
    endcase
  end

  // reset forces strobes low immediately, even before state settles
  assign irWrite    = ir_w  & rst_n;
  assign pcWrite    = pc_w  & rst_n;
  assign memRead    = mem_r & rst_n;
  assign memWrite   = mem_w & rst_n;
  assign regWrite   = reg_w & rst_n;
  assign illegal    = ill   & rst_n;
  assign instr_done = (nxt == S_FETCH) && (st != S_FETCH) && rst_n;
  assign state      = st;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed vectors against a state-sequence model.
// Two DUTs run in lockstep, one per TRAP_ON_ILLEGAL setting.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opCode = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic [1:0] a_sa, a_sb, a_op, a_rs, b_sa, b_sb, b_op, b_rs;
  logic       a_adr, a_ir, a_pc, a_rd, a_wr, a_rw, a_done, a_ill;
  logic       b_adr, b_ir, b_pc, b_rd, b_wr, b_rw, b_done, b_ill;
  logic [3:0] a_st, b_st;

  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .opCode(opCode), .zero(zero),
    .mem_ready(mem_ready), .ALUSrcA(a_sa), .ALUSrcB(a_sb),
    .ALUOp(a_op), .resultSrc(a_rs), .adrSrc(a_adr),
    .irWrite(a_ir), .pcWrite(a_pc), .memRead(a_rd),
    .memWrite(a_wr), .regWrite(a_rw), .instr_done(a_done),
    .illegal(a_ill), .state(a_st));

  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .opCode(opCode), .zero(zero),
    .mem_ready(mem_ready), .ALUSrcA(b_sa), .ALUSrcB(b_sb),
    .ALUOp(b_op), .resultSrc(b_rs), .adrSrc(b_adr),
    .irWrite(b_ir), .pcWrite(b_pc), .memRead(b_rd),
    .memWrite(b_wr), .regWrite(b_rw), .instr_done(b_done),
    .illegal(b_ill), .state(b_st));

  always #5 clk = ~clk;

  logic [19:0] pack_a, pack_b;
  assign pack_a = {a_st, a_sa, a_sb, a_op, a_rs, a_adr, a_ir,
                   a_pc, a_rd, a_wr, a_rw, a_done, a_ill};
  assign pack_b = {b_st, b_sa, b_sb, b_op, b_rs, b_adr, b_ir,
                   b_pc, b_rd, b_wr, b_rw, b_done, b_ill};

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [19:0] act, logic [19:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  localparam logic [6:0] R    = 7'b0110011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0000111;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] ADDI = 7'b0000010;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] BAD  = 7'b1111111;

  function automatic bit legal(logic [6:0] op);
    return op inside {R, LW, SW, BR, ADDI, JAL, JALR};
  endfunction

  // Output table per state, straight from the control description.
  function automatic logic [19:0] model(int s, logic [6:0] op,
      logic z, logic mr, bit trap, bit done);
    logic [1:0] a = 0, b = 0, alu = 0, rs = 0;
    logic adr = 0, ir = 0, pc = 0, rd = 0;
    logic wr = 0, rw = 0, il = 0, rdy;
    logic [3:0] sc;
`ifdef MEM_READY_EN
    rdy = mr;
`else
    rdy = 1'b1;
`endif
    sc = s[3:0];
    case (s)
      0:  begin rd = 1; b = 2; rs = 2; ir = rdy; pc = rdy; end
      1:  begin a = 1; b = 1; il = !trap && !legal(op); end
      2:  begin a = 2; b = 1; end
      3:  begin adr = 1; rd = 1; end
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; wr = 1; end
      6:  begin a = 2; alu = 2; end
      7:  begin a = 2; b = 1; alu = 3; end
      8:  rw = 1;
      9:  begin a = 2; alu = 1; pc = z; end
      10: begin a = 1; b = 2; pc = 1; end
      11: begin a = 2; b = 1; end
      12: begin a = 1; b = 2; pc = 1; end
      15: il = 1;
      default: ;
    endcase
    return {sc, a, b, alu, rs, adr, ir, pc, rd, wr, rw, done, il};
  endfunction

  function automatic bit is_done(int s, int n);
    return s != 0 && s != 15 && n == 0;
  endfunction

  int q_sa[$], q_sb[$], q_mr[$];
  logic [6:0] q_op[$];

  task automatic push(int sa, int sb, int mr, logic [6:0] op);
    q_sa.push_back(sa);
    q_sb.push_back(sb);
    q_mr.push_back(mr);
    q_op.push_back(op);
  endtask

  task automatic mem_wait(int s, int waits, logic [6:0] op);
`ifdef MEM_READY_EN
    for (int i = 0; i < waits; i++) push(s, s, 0, op);
    push(s, s, 1, op);
`else
    push(s, s, (waits > 0) ? 0 : 1, op);
`endif
  endtask

  // Expected state walk for one legal instruction.
  task automatic build(logic [6:0] op, int waits, bit scr);
    logic [6:0] o2;
    o2 = scr ? BAD : op;
    push(0, 0, 1, op);
    push(1, 1, 1, op);
    case (op)
      R:    begin push(6, 6, 1, o2); push(8, 8, 1, o2); end
      ADDI: begin push(7, 7, 1, o2); push(8, 8, 1, o2); end
      BR:   push(9, 9, 1, o2);
      JAL:  begin push(10, 10, 1, o2); push(8, 8, 1, o2); end
      JALR: begin
        push(11, 11, 1, o2); push(12, 12, 1, o2);
        push(8, 8, 1, o2);
      end
      LW: begin
        push(2, 2, 1, op); mem_wait(3, waits, o2);
        push(4, 4, 1, o2);
      end
      SW: begin push(2, 2, 1, op); mem_wait(5, waits, o2); end
      default: ;
    endcase
  endtask

  logic [19:0] exp_a, exp_b;
  bit exp_on = 0;
  int p_cyc, p_rw, p_pc, p_rd, p_ilb;

  always @(negedge clk) begin
    if (exp_on) begin
      chk("dut_trap", pack_a, exp_a);
      chk("dut_nop", pack_b, exp_b);
    end
  end

  // Entered at posedge+1 with both DUTs in the first queued state.
  task automatic play();
    int n = q_sa.size();
    p_cyc = 0; p_rw = 0; p_pc = 0; p_rd = 0; p_ilb = 0;
    for (int k = 0; k < n; k++) begin
      int na, nb;
      na = (k + 1 < n) ? q_sa[k+1] : 0;
      nb = (k + 1 < n) ? q_sb[k+1] : 0;
      opCode = q_op[k];
      mem_ready = q_mr[k][0];
      exp_a = model(q_sa[k], q_op[k], zero, q_mr[k][0], 1,
                    is_done(q_sa[k], na));
      exp_b = model(q_sb[k], q_op[k], zero, q_mr[k][0], 0,
                    is_done(q_sb[k], nb));
      exp_on = 1;
      @(negedge clk);
      if (a_done && p_cyc == 0) p_cyc = k + 1;
      if (a_rw) p_rw++;
      if (a_pc) p_pc++;
      if (a_rd) p_rd++;
      if (b_ill) p_ilb++;
      @(posedge clk); #1;
    end
    exp_on = 0;
    mem_ready = 1'b1;
    q_sa.delete(); q_sb.delete(); q_mr.delete(); q_op.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_state", {16'd0, a_st}, 20'd0);
    chk("rst_strobes", {13'd0, a_ir, a_pc, a_rd, a_wr, a_rw,
        a_done, a_ill}, 20'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    build(R, 0, 0); play();
    chk("r_cycles", p_cyc, 4);
    chk("r_regwrite", p_rw, 1);

    build(R, 0, 1); play();
    chk("r_scrambled_cycles", p_cyc, 4);

    build(LW, 3, 0); play();
`ifdef MEM_READY_EN
    chk("lw_cycles", p_cyc, 8);
    chk("lw_memread", p_rd, 5);
`else
    chk("lw_cycles", p_cyc, 5);
    chk("lw_memread", p_rd, 2);
`endif
    chk("lw_regwrite", p_rw, 1);

    build(SW, 0, 0); play();
    chk("sw_cycles", p_cyc, 4);

    build(ADDI, 0, 0); play();
    chk("addi_cycles", p_cyc, 4);

    zero = 1'b1;
    build(BR, 0, 0); play();
    chk("br_taken_cycles", p_cyc, 3);
    chk("br_taken_pcwrite", p_pc, 2);
    zero = 1'b0;
    build(BR, 0, 0); play();
    chk("br_not_cycles", p_cyc, 3);
    chk("br_not_pcwrite", p_pc, 1);

    build(JAL, 0, 0); play();
    chk("jal_cycles", p_cyc, 4);

    build(JALR, 0, 0); play();
    chk("jalr_cycles", p_cyc, 5);
    chk("jalr_pcwrite", p_pc, 2);
    chk("jalr_regwrite", p_rw, 1);

    push(0, 0, 1, BAD);
    push(1, 1, 1, BAD);
    for (int i = 0; i < 20; i++)
      push(15, (i % 2 == 0) ? 0 : 1, 1, BAD);
    play();
    chk("trap_state", {16'd0, a_st}, 20'd15);
    chk("trap_illegal", {19'd0, a_ill}, 20'd1);
    chk("nop_illegal_pulses", p_ilb, 11);

    do_reset();
    mem_ready = 1'b1;
    opCode = SW;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #2;
    chk("memwr_before_rst", {19'd0, a_wr}, 20'd1);
    rst_n = 1'b0;
    #1;
    chk("memwr_async_drop", {19'd0, a_wr}, 20'd0);
    chk("state_async_rst", {16'd0, a_st}, 20'd0);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_fetch", {17'd0, a_rd, a_ir, a_pc}, 20'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the RV subset decoded by the single-cycle main control: R-type, lw, sw, branch, addi3, plus jal/jalr.
- Drives a shared-ALU, shared-memory multicycle datapath one state per clock.
- Emits mux selects, ALUOp and write strobes, and waits on a memory-ready handshake.

Parameters:
- TRAP_ON_ILLEGAL, 1, 1: illegal opcode enters TRAP and halts; 0: illegal opcode returns to FETCH as a NOP with `illegal` pulsed for one cycle.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opCode  in  7  IR[6:0], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- ALUSrcA  out  2  00 PC, 01 oldPC, 10 regA
- ALUSrcB  out  2  00 regB, 01 imm, 10 const 4
- ALUOp  out  2  00 add, 01 sub, 10 funct decode, 11 addi3
- resultSrc  out  2  00 ALUOut, 01 memData, 10 ALUResult
- adrSrc  out  1  0 PC, 1 ALUOut
- irWrite, pcWrite, memRead, memWrite, regWrite  out  1 each  strobes
- instr_done  out  1  pulse on the final cycle of each instruction
- illegal  out  1  illegal opcode flag
- state  out  4  current state code, for debug

Behaviour:
- Reset (async, rst_n=0): state=FETCH(0); all strobes, instr_done and illegal = 0. Reset mid-instruction aborts it with no write strobe.
- Defaults: any select not listed below is 00; any strobe not listed is 0.
- Opcode map: R 0110011, lw 0000011, sw 0000111, branch 1100011, addi3 0000010, jal 1101111, jalr 1100111. Anything else is illegal.
- FETCH(0): adrSrc=0, memRead=1, A=00, B=10, ALUOp=00, resultSrc=10. irWrite=pcWrite=mem_ready. Stay while !mem_ready, else DECODE.
- DECODE(1): A=01, B=01, ALUOp=00 (branch target into ALUOut). Next state:
  - lw/sw -> MEMADR
  - R -> EXECR
  - addi3 -> EXECI
  - branch -> BRANCH
  - jal -> JAL
  - jalr -> JALR
  - illegal -> TRAP, or FETCH when TRAP_ON_ILLEGAL=0
- MEMADR(2): A=10, B=01, ALUOp=00; lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD(3): adrSrc=1, memRead=1; hold until mem_ready, then MEMWB.
- MEMWB(4): resultSrc=01, regWrite=1 -> FETCH.
- MEMWRITE(5): adrSrc=1, memWrite=1; hold until mem_ready, then FETCH. memWrite stays high while waiting.
- EXECR(6): A=10, B=00, ALUOp=10 -> ALUWB.
- EXECI(7): A=10, B=01, ALUOp=11 -> ALUWB.
- ALUWB(8): resultSrc=00, regWrite=1 -> FETCH.
- BRANCH(9): A=10, B=00, ALUOp=01, resultSrc=00. pcWrite=zero, combinational in this state only. -> FETCH.
- JAL(10): A=01, B=10, ALUOp=00, resultSrc=00, pcWrite=1 (PC<=target) -> ALUWB, which writes oldPC+4.
- JALR(11): A=10, B=01, ALUOp=00 -> JALR2.
- JALR2(12): A=01, B=10, resultSrc=00, pcWrite=1 -> ALUWB.
- TRAP(15): all strobes 0, illegal=1; held until reset. Codes 13-14 are unreachable and go to FETCH.
- instr_done=1 in the cycle whose next state is FETCH (excluding the FETCH wait itself).
- Latency with mem_ready=1 (FETCH through last state): R 4, lw 5, sw 4, branch 3, addi3 4, jal 4, jalr 5 cycles.
- opCode is sampled only in DECODE and MEMADR; IR changes elsewhere have no effect.

Optional Feature:
- Macro MEM_READY_EN.
- Defined: mem_ready gates FETCH, MEMREAD and MEMWRITE as described above.
- Undefined: mem_ready port remains but is ignored and treated as constant 1. Memory is single-cycle and the latencies above are fixed.

Test Plan:
- Reset: rst_n=0 asserted mid-MEMWRITE -> memWrite drops asynchronously, state=0. First fetch after release: memRead=1, irWrite=1, pcWrite=1.
- R-type 0110011: states 0,1,6,8. ALUOp=10 in EXECR; regWrite=1 only in cycle 4; instr_done=1 in cycle 4.
- lw with mem_ready low for 3 cycles in MEMREAD (MEM_READY_EN defined) -> 8 cycles total, memRead held high, regWrite=1 with resultSrc=01 once. Same stimulus with the macro undefined -> 5 cycles.
- Branch with zero=1 -> pcWrite=1 in state 9, resultSrc=00. With zero=0 -> pcWrite=0. Both take 3 cycles.
- jalr -> states 0,1,11,12,8. pcWrite=1 in state 12; regWrite=1 in state 8 with resultSrc=00.
- Illegal opcode 1111111: TRAP_ON_ILLEGAL=1 -> state=15, illegal stays 1, no strobes for 20 cycles. TRAP_ON_ILLEGAL=0 -> one-cycle illegal pulse, then back to FETCH.
